regfile_scoreboard: RTL and testbench

Parametrised multi-read-port register file for the pipelined core, replacing the fixed 2-read, negedge-write file. Adds write-to-read bypass, a per-register pending scoreboard for hazard/stall detection, hardwired zero register and a sequenced clear engine. It sits in decode: reads feed operand latches and pending flags feed the hazard unit; the write port is driven from writeback.

---
 rtl/regfile_scoreboard_pkg.sv | 13 +
 rtl/regfile_scoreboard_sb.sv | 44 ++++
 rtl/regfile_scoreboard.sv | 113 +++++++++++
 tb/tb_regfile_scoreboard.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and clear-engine state encoding for the decode-stage register file.
package regfile_scoreboard_pkg;

  localparam int RF_WORD    = 32;
  localparam int RF_REG_NUM = 32;
  localparam int RF_ADDR_W  = 5;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Pending-producer scoreboard (rf_scoreboard): one bit per register, set on issue,
// cleared on writeback or by the sequenced clear index, looked up per read port.
module regfile_scoreboard_sb #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_idx,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_idx,
  input  logic                     seq_en,
  input  logic [ADDR_W-1:0]        seq_idx,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_pend
);

  logic [REG_NUM-1:0] pend, pend_n;

  // A fresh issue outranks a same-edge writeback: the new producer still owes a result.
  always_comb begin
    pend_n = pend;
    for (int r = 0; r < REG_NUM; r++) begin
      if (set_en && set_idx == ADDR_W'(r))
        pend_n[r] = 1'b1;
      else if ((clr_en && clr_idx == ADDR_W'(r)) || (seq_en && seq_idx == ADDR_W'(r)))
        pend_n[r] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_n;
  end

  always_comb begin
    rd_pend = '0;
    for (int i = 0; i < NUM_RD; i++)
      rd_pend[i] = pend[rd_addr[i*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with pending scoreboard, zero register and sequenced clear.
// Define RF_BYPASS_EN to forward same-cycle writeback data/pending onto the read ports.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int WORD     = RF_WORD,
  parameter int REG_NUM  = RF_REG_NUM,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WORD-1:0]          wr_data,
  output logic                     wr_ready,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WORD-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  logic [REG_NUM-1:0][WORD-1:0] regs;
  rf_state_e                    state, state_n;
  logic [ADDR_W-1:0]            cnt, cnt_n;
  logic                         clearing, wr_acc, iss_acc;
  logic [NUM_RD-1:0]            sb_pend;

  assign clearing = (state == RF_CLEAR);
  assign wr_ready = ~clearing;
  assign clr_busy = clearing;
  assign wr_acc   = wr_en  & wr_ready & ~((ZERO_REG != 0) && (wr_addr  == '0));
  assign iss_acc  = iss_en & ~clearing & ~((ZERO_REG != 0) && (iss_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RF_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      RF_IDLE: begin
        if (clr_req) begin
          state_n = RF_CLEAR;
          cnt_n   = '0;
        end
      end
      RF_CLEAR: begin
        cnt_n = cnt + 1'b1;
        if (cnt == ADDR_W'(REG_NUM - 1)) begin
          state_n = RF_IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = RF_IDLE;
    endcase
  end

  // Clear owns the array while running; writeback is refused via wr_ready, not queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        regs          <= '0;
    else if (clearing) regs[cnt]     <= '0;
    else if (wr_acc)   regs[wr_addr] <= wr_data;
  end

  regfile_scoreboard_sb #(
    .REG_NUM (REG_NUM),
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (iss_acc),
    .set_idx (iss_addr),
    .clr_en  (wr_acc),
    .clr_idx (wr_addr),
    .seq_en  (clearing),
    .seq_idx (cnt),
    .rd_addr (rd_addr),
    .rd_pend (sb_pend)
  );

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_pend = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[i*ADDR_W +: ADDR_W];
      rd_data[i*WORD +: WORD] = ((ZERO_REG != 0) && (ra == '0)) ? '0 : regs[ra];
      rd_pend[i] = sb_pend[i];
`ifdef RF_BYPASS_EN
      // wr_acc already excludes the zero register and the clear window.
      if (wr_acc && (wr_addr == ra)) begin
        rd_data[i*WORD +: WORD] = wr_data;
        if (!(iss_en && (iss_addr == ra))) rd_pend[i] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed + randomized bench for regfile_scoreboard against an array/queue-level model.
module tb_regfile_scoreboard;

  localparam int W  = 32;
  localparam int RN = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0, iss_en = 1'b0, clr_req = 1'b0;
  logic [AW-1:0]   wr_addr = '0, iss_addr = '0;
  logic [W-1:0]    wr_data = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic            wr_ready, clr_busy;
  logic [NR*W-1:0] rd_data;
  logic [NR-1:0]   rd_pend;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_reg [RN];
  bit           m_pend [RN];
  bit           m_busy;
  int           m_cnt;

  regfile_scoreboard #(
    .WORD(W), .REG_NUM(RN), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit fwd_hit(input int ra);
    return !m_busy && wr_en && (int'(wr_addr) == ra) && (ra != 0);
  endfunction

  function automatic logic [W-1:0] exp_data(input int ra);
    if (ra == 0) return '0;
`ifdef RF_BYPASS_EN
    if (fwd_hit(ra)) return wr_data;
`endif
    return m_reg[ra];
  endfunction

  function automatic logic exp_pend(input int ra);
`ifdef RF_BYPASS_EN
    if (fwd_hit(ra) && !(iss_en && int'(iss_addr) == ra)) return 1'b0;
`endif
    return m_pend[ra];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < RN; r++) begin
      m_reg[r]  = '0;
      m_pend[r] = 1'b0;
    end
    m_busy = 1'b0;
    m_cnt  = 0;
  endtask

  // Architectural effect of one rising edge, in plain sequential terms.
  task automatic model_edge();
    if (m_busy) begin
      m_reg[m_cnt]  = '0;
      m_pend[m_cnt] = 1'b0;
      m_cnt++;
      if (m_cnt == RN) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_reg[wr_addr]  = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
      if (clr_req) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  endtask

  task automatic check_all();
    int ra;
    chk("wr_ready", 32'(wr_ready), 32'(!m_busy));
    chk("clr_busy", 32'(clr_busy), 32'(m_busy));
    for (int i = 0; i < NR; i++) begin
      ra = int'(rd_addr[i*AW +: AW]);
      chk($sformatf("rd_data%0d[r%0d]", i, ra), rd_data[i*W +: W], exp_data(ra));
      chk($sformatf("rd_pend%0d[r%0d]", i, ra), 32'(rd_pend[i]), 32'(exp_pend(ra)));
    end
  endtask

  // Inputs change at posedge+1; outputs checked mid-cycle; model advanced on the edge.
  task automatic tick();
    #4 check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic idle();
    wr_en = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
  endtask

  int n;
  logic [W-1:0] pk [NR];

  initial begin
    // Reset state
    model_reset();
    set_rd(5, 0, 31, 7);
    #3 check_all();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); model_edge(); #1;

    // Basic write/read and zero register
    wr(5, 32'hDEADBEEF); tick();
    idle(); set_rd(5, 0, 1, 2); tick();
    chk("r5_read", rd_data[0 +: W], 32'hDEADBEEF);
    wr(0, 32'h1234); set_rd(0, 0, 5, 0); tick();
    idle(); tick();
    chk("r0_zero", rd_data[0 +: W], 32'h0);

    // Same-cycle write vs read of R7
    wr(7, 32'hA5A5A5A5); set_rd(0, 7, 0, 0);
    #4;
`ifdef RF_BYPASS_EN
    chk("bypass_r7", rd_data[W +: W], 32'hA5A5A5A5);
`else
    chk("nobypass_r7", rd_data[W +: W], 32'h0);
`endif
    #0 tick();
    idle(); tick();
    chk("r7_after", rd_data[W +: W], 32'hA5A5A5A5);

    // Scoreboard set / set-wins / clear
    iss_en = 1'b1; iss_addr = 5'd3; set_rd(3, 3, 3, 3); tick();
    idle(); tick();
    chk("pend_r3_set", 32'(rd_pend[0]), 32'd1);
    wr(3, 32'h33); iss_en = 1'b1; iss_addr = 5'd3; tick();
    idle(); tick();
    chk("pend_set_wins", 32'(rd_pend[1]), 32'd1);
    wr(3, 32'h34); tick();
    idle(); tick();
    chk("pend_cleared", 32'(rd_pend[2]), 32'd0);
    iss_en = 1'b1; iss_addr = 5'd0; set_rd(0, 0, 0, 0); tick();
    idle(); tick();
    chk("pend_r0_ignored", 32'(rd_pend[0]), 32'd0);

    // Randomized traffic including occasional clears
    for (int c = 0; c < 400; c++) begin
      wr_en    = ($urandom % 2) != 0;
      wr_addr  = AW'($urandom);
      wr_data  = $urandom;
      iss_en   = ($urandom % 3) == 0;
      iss_addr = ($urandom % 2) != 0 ? wr_addr : AW'($urandom);
      clr_req  = ($urandom % 80) == 0;
      set_rd(int'(wr_addr), $urandom % RN, int'(iss_addr), $urandom % RN);
      tick();
    end
    idle();
    for (int c = 0; c < 40 && m_busy; c++) tick();

    // Fill, then full clear with a dropped write inside the window
    for (int r = 1; r < RN; r++) begin
      wr(r, W'(r)); iss_en = 1'b1; iss_addr = AW'(r ^ 1); tick();
    end
    idle(); set_rd(2, 8, 9, 31); tick();
    clr_req = 1'b1; tick();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 40) begin
      n++;
      if (n == 5) wr(2, 32'hFFFF);
      if (n == 6) begin wr_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd2; end
      if (n == 7) iss_en = 1'b0;
      tick();
    end
    chk("clr_len", W'(n), 32'd32);
    idle();
    for (int b = 0; b < RN; b += 4) begin
      set_rd(b, b + 1, b + 2, b + 3); tick();
      chk($sformatf("post_clr_r%0d", b + 2), rd_data[2*W +: W], 32'h0);
      chk($sformatf("post_clr_pend_r%0d", b + 2), 32'(rd_pend), 32'h0);
    end

    // Reset in the middle of a clear
    for (int r = 1; r < RN; r++) begin wr(r, 32'hC0DE0000 | W'(r)); tick(); end
    idle(); clr_req = 1'b1; tick();
    clr_req = 1'b0;
    repeat (10) tick();
    chk("cnt10_busy", 32'(clr_busy), 32'd1);
    set_rd(9, 10, 20, 31);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_abort_busy", 32'(clr_busy), 32'd0);
    chk("rst_abort_r20", rd_data[2*W +: W], 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); model_edge(); #1;
    wr(20, 32'h600DF00D); tick();
    idle(); tick();
    chk("write_after_rst", rd_data[2*W +: W], 32'h600DF00D);

    // Four distinct ports, packing
    for (int i = 0; i < NR; i++) begin
      pk[i] = $urandom;
      wr(12 + i, pk[i]); tick();
    end
    idle(); set_rd(15, 13, 12, 14); tick();
    chk("pack_p0", rd_data[0*W +: W], pk[3]);
    chk("pack_p1", rd_data[1*W +: W], pk[1]);
    chk("pack_p2", rd_data[2*W +: W], pk[0]);
    chk("pack_p3", rd_data[3*W +: W], pk[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
